// File: rtl/cla_pkg.sv
// Shared definitions for the chunked carry-lookahead adder: FSM encoding and
// index-counter sizing.
package cla_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // A counter for a single chunk still needs one bit.
  function automatic int unsigned idx_width(input int unsigned chunks);
    if (chunks > 1) begin
      return $clog2(chunks);
    end
    return 1;
  endfunction

endpackage

// File: rtl/CarryLookAheadAdder_v20.sv
// Combinational WIDTH-bit carry-lookahead adder; every carry is expanded
// directly from generate/propagate terms rather than rippled.
module CarryLookAheadAdder_v20 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = i_A & i_B;
  assign prop = i_A ^ i_B;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
  always_comb begin
    logic pp;
    logic cn;
    pp       = 1'b0;
    cn       = 1'b0;
    carry    = '0;
    carry[0] = i_Cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cn = gen[i];
      pp = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        cn = cn | (pp & gen[j]);
        pp = pp & prop[j];
      end
      cn = cn | (pp & i_Cin);
      carry[i+1] = cn;
    end
  end

  assign o_Sum  = prop ^ carry[WIDTH-1:0];
  assign o_Cout = carry[WIDTH];

endmodule

// File: rtl/cla_multiword_adder.sv
// Multi-cycle wide adder: one WIDTH-bit chunk per clock through a single CLA,
// LSB chunk first, with the inter-chunk carry held in a register.
module cla_multiword_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CHUNKS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [WIDTH*CHUNKS-1:0]   i_A,
  input  logic [WIDTH*CHUNKS-1:0]   i_B,
  input  logic                      i_Cin,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [WIDTH*CHUNKS-1:0]   o_Sum,
  output logic                      o_Cout,
  output logic                      o_busy
);

  localparam int unsigned TW   = WIDTH * CHUNKS;
  localparam int unsigned IdxW = idx_width(CHUNKS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHUNKS - 1);

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic [TW-1:0]   a_q;
  logic [TW-1:0]   b_q;
  logic [TW-1:0]   sum_q;
  logic            cout_q;

  logic [WIDTH-1:0] chunk_a;
  logic [WIDTH-1:0] chunk_b;
  logic [WIDTH-1:0] chunk_sum;
  logic             chunk_cout;

  assign chunk_a = a_q[idx_q*WIDTH +: WIDTH];
  assign chunk_b = b_q[idx_q*WIDTH +: WIDTH];

  CarryLookAheadAdder_v20 #(
    .WIDTH (WIDTH)
  ) u_cla (
    .i_A    (chunk_a),
    .i_B    (chunk_b),
    .i_Cin  (carry_q),
    .o_Sum  (chunk_sum),
    .o_Cout (chunk_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_valid) begin
            a_q     <= i_A;
            b_q     <= i_B;
            carry_q <= i_Cin;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[idx_q*WIDTH +: WIDTH] <= chunk_sum;
          carry_q                     <= chunk_cout;
          if (idx_q == LastIdx) begin
            cout_q  <= chunk_cout;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (i_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_busy  = (state_q == StRun);
  assign o_valid = (state_q == StDone);
  assign o_Sum   = sum_q;
  assign o_Cout  = cout_q;

endmodule

// File: tb/tb_cla_multiword_adder.sv
// Scoreboard bench for the chunked CLA adder: 4x4-bit instance with directed and
// random operands, plus a 1x4-bit instance swept exhaustively.
module tb_cla_multiword_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, c0 = 1'b0, v1 = 1'b0, c1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        rdy_dir = 1'b1, rdy_rnd = 1'b1, rdy_rand = 1'b0;
  logic        i_ready;
  assign i_ready = rdy_rand ? rdy_rnd : rdy_dir;

  logic        r0, val0, busy0, cout0, r1, val1, busy1, cout1;
  logic [15:0] sum0;
  logic [3:0]  sum1;

  int n_vec = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];
  logic [4:0]  exp1_q[$];
  logic [16:0] e0;
  logic [4:0]  e1;

  cla_multiword_adder #(.WIDTH(4), .CHUNKS(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(r0), .i_A(a0), .i_B(b0),
    .i_Cin(c0), .o_valid(val0), .i_ready(i_ready), .o_Sum(sum0), .o_Cout(cout0),
    .o_busy(busy0)
  );

  cla_multiword_adder #(.WIDTH(4), .CHUNKS(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(r1), .i_A(a1), .i_B(b1),
    .i_Cin(c1), .o_valid(val1), .i_ready(i_ready), .o_Sum(sum1), .o_Cout(cout1),
    .o_busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Scoreboard monitors: a result is consumed on a cycle with valid and ready.
  always @(negedge clk) begin
    if (val0 && i_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL c4 unexpected result: got 0x%0h, expected none", {cout0, sum0});
      end else begin
        e0 = exp_q.pop_front();
        check("c4 {cout,sum}", {15'd0, cout0, sum0}, {15'd0, e0});
      end
    end
  end

  always @(negedge clk) begin
    if (val1 && i_ready) begin
      if (exp1_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL c1 unexpected result: got 0x%0h, expected none", {cout1, sum1});
      end else begin
        e1 = exp1_q.pop_front();
        check("c1 {cout,sum}", {27'd0, cout1, sum1}, {27'd0, e1});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rdy_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic issue0(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int t = 0;
    @(negedge clk);
    while (!r0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!r0) begin
      timeout_fail("issue c4 o_ready");
      return;
    end
    v0 = 1'b1; a0 = a; b0 = b; c0 = cin;
    @(posedge clk);
    exp_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
    #1 v0 = 1'b0;
  endtask

  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int t = 0;
    @(negedge clk);
    while (!r1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!r1) begin
      timeout_fail("issue c1 o_ready");
      return;
    end
    v1 = 1'b1; a1 = a; b1 = b; c1 = cin;
    @(posedge clk);
    exp1_q.push_back({1'b0, a} + {1'b0, b} + {4'd0, cin});
    #1 v1 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || exp1_q.size() != 0) timeout_fail("drain scoreboard");
  endtask

  initial begin
    int busy_cnt;
    int t;

    repeat (3) @(negedge clk);
    check("reset o_ready", r0, 1);
    check("reset o_valid", val0, 0);
    check("reset o_busy", busy0, 0);
    check("reset o_Sum", sum0, 0);
    check("reset o_Cout", cout0, 0);
    rst_n = 1'b1;

    // Zero operands; o_valid must rise exactly four edges after accept.
    issue0(16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("valid before latency", val0, 0);
    end
    @(negedge clk);
    check("valid at accept+4", val0, 1);
    drain();

    issue0(16'hFFFF, 16'h0001, 1'b0);
    drain();

    // o_busy must be high for exactly four cycles.
    issue0(16'h1234, 16'h4321, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
    end
    check("busy cycle count", busy_cnt, 4);
    drain();

    // Stall in DONE with new operands offered; result must hold.
    rdy_dir = 1'b0;
    issue0(16'hABCD, 16'h8000, 1'b0);
    t = 0;
    @(negedge clk);
    while (!val0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!val0) timeout_fail("stall o_valid");
    v0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; c0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall o_Sum", sum0, 16'h2BCD);
      check("stall o_Cout", cout0, 1);
      check("stall o_ready", r0, 0);
      check("stall o_valid", val0, 1);
    end
    @(posedge clk);
    #1 v0 = 1'b0; rdy_dir = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("o_ready after release", r0, 1);
    drain();

    // Reset while the third chunk is being added.
    issue0(16'h1234, 16'h1111, 1'b0);
    repeat (3) @(negedge clk);
    check("pre-reset busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    check("mid-run reset o_valid", val0, 0);
    check("mid-run reset o_ready", r0, 1);
    check("mid-run reset o_Sum", sum0, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue0(16'h8000, 16'h8000, 1'b1);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      issue0(16'($urandom), 16'($urandom), 1'($urandom));
    end
    drain();

    // Single-chunk instance: RUN is one cycle, then exhaustive sweep.
    for (int i = 0; i < 512; i++) begin
      issue1(4'(i >> 5), 4'(i >> 1), i[0]);
      if (i == 0) begin
        @(negedge clk);
        check("c1 busy one cycle", busy1, 1);
        @(negedge clk);
        check("c1 valid after one run", val1, 1);
      end
    end
    drain();
    rdy_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
